hazard_pc_ctrl: RTL and testbench

HAZARD_PC_CTRL -- requirements
Module: hazard_pc_ctrl

---
 rtl/hazard_pc_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_pc_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pc_ctrl.sv
// Load-use hazard detection and PC sequencing control: stalls, bubbles, branch flushes.
// Optional macro HAZARD_PC_CTRL_STALL_CNT_EN adds a saturating stall counter output.
module hazard_pc_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned PC_STEP      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RegRt_i,
    input  logic [4:0]  IFID_RegRs_i,
    input  logic [4:0]  IFID_RegRt_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_next_o,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IDEX_bubble_o,
    output logic        IFID_flush_o,
    output logic [1:0]  state_o
`ifdef HAZARD_PC_CTRL_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt_o
`endif
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] STALL = 2'b10;
    localparam logic [1:0] FLUSH = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        hazard;
    logic [31:0] pc_seq;

    assign hazard = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
                    ((IDEX_RegRt_i == IFID_RegRs_i) || (IDEX_RegRt_i == IFID_RegRt_i));
    assign pc_seq  = pc_i + PC_STEP;
    assign state_o = state_q;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        pc_next_o     = pc_i;
        PCWrite_o     = 1'b0;
        IFIDWrite_o   = 1'b0;
        IDEX_bubble_o = 1'b0;
        IFID_flush_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN, STALL: begin
                if (!start_i) begin
                    state_d     = IDLE;
                    flush_cnt_d = 3'd0;
                end else if (branch_taken_i) begin
                    // Branch outranks a simultaneous load-use hazard.
                    PCWrite_o    = 1'b1;
                    IFIDWrite_o  = 1'b1;
                    IFID_flush_o = 1'b1;
                    pc_next_o    = branch_target_i;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = 3'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = RUN;
                    end
                end else if (hazard) begin
                    IDEX_bubble_o = 1'b1;
                    state_d       = STALL;
                end else begin
                    PCWrite_o   = 1'b1;
                    IFIDWrite_o = 1'b1;
                    pc_next_o   = pc_seq;
                    state_d     = RUN;
                end
            end
            FLUSH: begin
                if (!start_i) begin
                    state_d     = IDLE;
                    flush_cnt_d = 3'd0;
                end else begin
                    PCWrite_o    = 1'b1;
                    IFIDWrite_o  = 1'b1;
                    IFID_flush_o = 1'b1;
                    pc_next_o    = pc_seq;
                    flush_cnt_d  = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1) state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        // Controls stay quiet for the whole reset cycle, not just after it.
        if (rst_i) begin
            pc_next_o     = pc_i;
            PCWrite_o     = 1'b0;
            IFIDWrite_o   = 1'b0;
            IDEX_bubble_o = 1'b0;
            IFID_flush_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef HAZARD_PC_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'd0;
        end else if (IDEX_bubble_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_pc_ctrl.sv
// Scoreboard bench for hazard_pc_ctrl: directed scenarios plus random traffic vs a reference model.
// Honours HAZARD_PC_CTRL_STALL_CNT_EN when the design is built with it.
module tb_hazard_pc_ctrl;

    localparam int unsigned FC   = 3;
    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        IDEX_MemRead_i = 1'b0;
    logic [4:0]  IDEX_RegRt_i = '0;
    logic [4:0]  IFID_RegRs_i = '0;
    logic [4:0]  IFID_RegRt_i = '0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] pc_next_o;
    logic        PCWrite_o, IFIDWrite_o, IDEX_bubble_o, IFID_flush_o;
    logic [1:0]  state_o;
`ifdef HAZARD_PC_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    hazard_pc_ctrl #(.FLUSH_CYCLES(FC), .PC_STEP(STEP)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .pc_i            (pc_i),
        .IDEX_MemRead_i  (IDEX_MemRead_i),
        .IDEX_RegRt_i    (IDEX_RegRt_i),
        .IFID_RegRs_i    (IFID_RegRs_i),
        .IFID_RegRt_i    (IFID_RegRt_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .pc_next_o       (pc_next_o),
        .PCWrite_o       (PCWrite_o),
        .IFIDWrite_o     (IFIDWrite_o),
        .IDEX_bubble_o   (IDEX_bubble_o),
        .IFID_flush_o    (IFID_flush_o),
        .state_o         (state_o)
`ifdef HAZARD_PC_CTRL_STALL_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    typedef struct packed {
        logic [31:0] pcn;
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic        fl;
        logic [1:0]  st;
        logic [15:0] sc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: running/stalled flags, remaining flush cycles, bubble count.
    bit m_run = 0;
    bit m_stall = 0;
    int m_flush = 0;
    int m_scnt = 0;

    task automatic drive(input logic r, input logic s, input logic [31:0] pc, input logic mr,
                         input logic [4:0] ldst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic br, input logic [31:0] tgt);
        exp_t e;
        bit   hz;
        @(negedge clk);
        rst_i = r; start_i = s; pc_i = pc; IDEX_MemRead_i = mr; IDEX_RegRt_i = ldst;
        IFID_RegRs_i = rs; IFID_RegRt_i = rt; branch_taken_i = br; branch_target_i = tgt;
        hz = mr && (ldst != 0) && (ldst == rs || ldst == rt);
        e.pcn = pc; e.pcw = 0; e.ifw = 0; e.bub = 0; e.fl = 0;
        e.st  = !m_run ? 2'd0 : (m_flush > 0) ? 2'd3 : m_stall ? 2'd2 : 2'd1;
        e.sc  = 16'(m_scnt);
        if (r) begin
            m_run = 0; m_stall = 0; m_flush = 0; m_scnt = 0;
        end else if (!m_run) begin
            m_run = s;
        end else if (!s) begin
            m_run = 0; m_stall = 0; m_flush = 0;
        end else if (m_flush > 0) begin
            e.pcw = 1; e.ifw = 1; e.fl = 1; e.pcn = pc + STEP;
            m_flush--;
        end else if (br) begin
            e.pcw = 1; e.ifw = 1; e.fl = 1; e.pcn = tgt;
            m_flush = FC - 1; m_stall = 0;
        end else if (hz) begin
            e.bub = 1; m_stall = 1;
            if (m_scnt < 65535) m_scnt++;
        end else begin
            e.pcw = 1; e.ifw = 1; e.pcn = pc + STEP; m_stall = 0;
        end
        sb_q.push_back(e);
    endtask

    task automatic go(input logic [31:0] pc);
        drive(0, 1, pc, 0, 5'd0, 5'd0, 5'd0, 0, 32'd0);
    endtask

    task automatic load_use(input logic [4:0] ldst);
        drive(0, 1, 32'h100, 1, ldst, ldst, 5'd9, 0, 32'd0);
    endtask

    // Monitor: outputs are combinational, so one sample per cycle after inputs settle.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                bad = (pc_next_o !== e.pcn) || (PCWrite_o !== e.pcw) || (IFIDWrite_o !== e.ifw) ||
                      (IDEX_bubble_o !== e.bub) || (IFID_flush_o !== e.fl) || (state_o !== e.st);
`ifdef HAZARD_PC_CTRL_STALL_CNT_EN
                if (stall_cnt_o !== e.sc) bad = 1;
`endif
                if (bad) begin
                    n_bad++;
                    $display("FAIL txn%0d @%0t: got pcn=%h pcw=%b ifw=%b bub=%b fl=%b st=%0d, want pcn=%h pcw=%b ifw=%b bub=%b fl=%b st=%0d sc=%0d",
                             n_cmp, $time, pc_next_o, PCWrite_o, IFIDWrite_o, IDEX_bubble_o,
                             IFID_flush_o, state_o, e.pcn, e.pcw, e.ifw, e.bub, e.fl, e.st, e.sc);
                end
            end
        end
    end

    initial begin
        int w;
        // Reset, then idle one cycle, then run from 0.
        drive(1, 1, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 32'd0);
        drive(1, 1, 32'h0, 1, 5'd3, 5'd3, 5'd0, 1, 32'h80);
        drive(0, 1, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 32'd0);
        go(32'h0);
        go(32'h4);
        // Load-use stall, then the same stimulus with $zero as destination.
        load_use(5'd5);
        go(32'h100);
        go(32'h104);
        load_use(5'd0);
        go(32'h108);
        // Repeated stall.
        load_use(5'd7);
        load_use(5'd7);
        go(32'h100);
        // Branch with concurrent hazard, flush runs three cycles.
        drive(0, 1, 32'h200, 1, 5'd5, 5'd5, 5'd0, 1, 32'h40);
        drive(0, 1, 32'h40, 1, 5'd5, 5'd5, 5'd0, 1, 32'h999);
        go(32'h44);
        go(32'h48);
        // Wraparound.
        go(32'hFFFF_FFFC);
        // Reset in the second FLUSH cycle.
        drive(0, 1, 32'h300, 0, 5'd0, 5'd0, 5'd0, 1, 32'h500);
        go(32'h500);
        drive(1, 1, 32'h504, 0, 5'd0, 5'd0, 5'd0, 0, 32'd0);
        go(32'h504);
        go(32'h508);
        go(32'h50C);
        // Start dropped while stalled.
        load_use(5'd4);
        drive(0, 0, 32'h100, 1, 5'd4, 5'd4, 5'd0, 0, 32'd0);
        go(32'h100);
        go(32'h100);
        // Three separate stalls, then reset clears the count.
        for (int i = 0; i < 3; i++) begin
            load_use(5'd6);
            go(32'h100);
        end
        drive(1, 1, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 32'd0);
        go(32'h0);
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) != 0),
                  ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0), $urandom);
        end
        w = 0;
        while (sb_q.size() > 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        #5;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected responses left, want 0", sb_q.size());
        end
        if (n_cmp < 12) begin
            n_bad++;
            $display("FAIL count: %0d comparisons made, want at least 12", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
